motor_plant_model: RTL and testbench

//   Plant-side counterpart of the motor control FSM. Consumes the motor_up /

---
 rtl/motor_plant_model_if.sv | 24 ++
 rtl/motor_plant_model.sv | 145 ++++++++++++++
 tb/tb_motor_plant_model.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/motor_plant_model_if.sv
// Command and limit-switch bundle between the motor controller and the plant model.
// The controller drives the commands through master; the plant drives the switches through slave.
interface motor_plant_model_if #(
  parameter int POS_W = 8
);
  logic             motor_up;
  logic             motor_dn;
  logic             clear_fault;
  logic             up_limit;
  logic             dn_limit;
  logic [POS_W-1:0] position;
  logic             moving;
  logic             fault;

  modport master (
    output motor_up, motor_dn, clear_fault,
    input  up_limit, dn_limit, position, moving, fault
  );

  modport slave (
    input  motor_up, motor_dn, clear_fault,
    output up_limit, dn_limit, position, moving, fault
  );
endinterface

// File: rtl/motor_plant_model.sv
// Synthesizable carriage plant: prescaled position stepping, reversal dead time,
// illegal-drive fault, and limit switches decoded from the registered position.
module motor_plant_model #(
  parameter int POS_W    = 8,
  parameter int POS_MAX  = 200,
  parameter int STEP_DIV = 16,
  parameter int DEAD_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  motor_plant_model_if.slave  bus
);

  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DEAD_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYC - 1);
  localparam logic [POS_W-1:0]   POS_TOP    = POS_W'(POS_MAX);

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DN,
    DEAD,
    FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [DEAD_W-1:0]    dead_q, dead_d;

  logic bothCmd;
  logic atTop;
  logic atBottom;

  assign bothCmd  = bus.motor_up & bus.motor_dn;
  assign atTop    = (pos_q == POS_TOP);
  assign atBottom = (pos_q == '0);

  // Async reset homes the carriage immediately, mid-move included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      presc_q <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    dead_d  = dead_q;

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bothCmd) begin
          state_d = FAULT;
        end else if (bus.motor_up && !atTop) begin
          state_d = UP;
        end else if (bus.motor_dn && !atBottom) begin
          state_d = DN;
        end
      end

      UP: begin
        if (bothCmd) begin
          state_d = FAULT;
        end else if (!bus.motor_up) begin
          presc_d = '0;
          if (bus.motor_dn) begin
            state_d = DEAD;
            dead_d  = DEAD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          pos_d   = pos_q + 1'b1;
          if (pos_q + 1'b1 == POS_TOP) begin
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      DN: begin
        if (bothCmd) begin
          state_d = FAULT;
        end else if (!bus.motor_dn) begin
          presc_d = '0;
          if (bus.motor_up) begin
            state_d = DEAD;
            dead_d  = DEAD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          pos_d   = pos_q - 1'b1;
          if (pos_q - 1'b1 == '0) begin
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      DEAD: begin
        if (bothCmd) begin
          state_d = FAULT;
        end else if (dead_q == '0) begin
          state_d = IDLE;
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end

      FAULT: begin
        if (bus.clear_fault && !bus.motor_up && !bus.motor_dn) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.up_limit = atTop;
  assign bus.dn_limit = atBottom;
  assign bus.position = pos_q;
  assign bus.moving   = (state_q == UP) || (state_q == DN);
  assign bus.fault    = (state_q == FAULT);

endmodule

// File: tb/tb_motor_plant_model.sv
// Directed bench for motor_plant_model with POS_MAX=20, STEP_DIV=4, DEAD_CYC=3;
// expected values are hand-derived from the stepping, dead-time and fault rules.
module tb_motor_plant_model;

  localparam int POS_W    = 8;
  localparam int POS_MAX  = 20;
  localparam int STEP_DIV = 4;
  localparam int DEAD_CYC = 3;

  logic clk;
  logic rst_n;

  int compareCount  = 0;
  int mismatchCount = 0;

  motor_plant_model_if #(.POS_W(POS_W)) plantIf ();

  motor_plant_model #(
    .POS_W   (POS_W),
    .POS_MAX (POS_MAX),
    .STEP_DIV(STEP_DIV),
    .DEAD_CYC(DEAD_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (plantIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports the observed vs expected value on mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives the commands, then advances the given number of clock edges, leaving
  // the bench 1 time unit after the last edge so outputs are stable for sampling.
  task automatic applyStimulus(input logic up, input logic dn, input logic clr, input int cycles);
    plantIf.motor_up    = up;
    plantIf.motor_dn    = dn;
    plantIf.clear_fault = clr;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    plantIf.motor_up    = 1'b0;
    plantIf.motor_dn    = 1'b0;
    plantIf.clear_fault = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("rst_position", int'(plantIf.position), 0);
    checkOutput("rst_dn_limit", int'(plantIf.dn_limit), 1);
    checkOutput("rst_up_limit", int'(plantIf.up_limit), 0);
    checkOutput("rst_moving",   int'(plantIf.moving),   0);
    checkOutput("rst_fault",    int'(plantIf.fault),    0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);

    // Driving down while already at the bottom is ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    checkOutput("dn_at_bottom_moving", int'(plantIf.moving), 0);
    checkOutput("dn_at_bottom_pos",    int'(plantIf.position), 0);

    // Full travel up: entry edge, then one step every 4 edges.
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("up_entry_moving", int'(plantIf.moving), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("up_prestep_pos",      int'(plantIf.position), 0);
    checkOutput("up_prestep_dn_limit", int'(plantIf.dn_limit), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("up_first_step_pos",      int'(plantIf.position), 1);
    checkOutput("up_first_step_dn_limit", int'(plantIf.dn_limit), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 75);
    checkOutput("up_near_top_pos",    int'(plantIf.position), 19);
    checkOutput("up_near_top_moving", int'(plantIf.moving),   1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("up_top_pos",      int'(plantIf.position), 20);
    checkOutput("up_top_up_limit", int'(plantIf.up_limit), 1);
    checkOutput("up_top_moving",   int'(plantIf.moving),   0);

    // Up command at the top is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 5);
    checkOutput("up_at_top_pos",    int'(plantIf.position), 20);
    checkOutput("up_at_top_moving", int'(plantIf.moving),   0);

    // Full travel down back to the bottom.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("dn_entry_moving", int'(plantIf.moving), 1);
    checkOutput("dn_entry_up_limit", int'(plantIf.up_limit), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4);
    checkOutput("dn_first_step_pos", int'(plantIf.position), 19);
    applyStimulus(1'b0, 1'b1, 1'b0, 76);
    checkOutput("dn_bottom_pos",      int'(plantIf.position), 0);
    checkOutput("dn_bottom_dn_limit", int'(plantIf.dn_limit), 1);
    checkOutput("dn_bottom_moving",   int'(plantIf.moving),   0);

    // Climb to 5, then reverse directly: 3 edges of DEAD, one IDLE, then DN.
    applyStimulus(1'b1, 1'b0, 1'b0, 21);
    checkOutput("rev_start_pos",    int'(plantIf.position), 5);
    checkOutput("rev_start_moving", int'(plantIf.moving),   1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("dead_1_moving", int'(plantIf.moving), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    checkOutput("dead_3_moving", int'(plantIf.moving),   0);
    checkOutput("dead_3_pos",    int'(plantIf.position), 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("dead_idle_moving", int'(plantIf.moving), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("dead_dn_entry_moving", int'(plantIf.moving), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    checkOutput("dead_dn_prestep_pos", int'(plantIf.position), 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("dead_dn_step_pos", int'(plantIf.position), 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("dn_release_moving", int'(plantIf.moving), 0);

    // Interrupted step: partial prescale count is discarded.
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("pulse_idle_moving", int'(plantIf.moving), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("pulse_no_early_step_pos", int'(plantIf.position), 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("pulse_step_pos", int'(plantIf.position), 5);

    // Illegal drive freezes the plant in FAULT until a clean clear.
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("fault_set",        int'(plantIf.fault),    1);
    checkOutput("fault_set_moving", int'(plantIf.moving),   0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6);
    checkOutput("fault_frozen_pos", int'(plantIf.position), 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    checkOutput("fault_clear_with_up", int'(plantIf.fault), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("fault_no_clear", int'(plantIf.fault), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("fault_cleared",     int'(plantIf.fault),    0);
    checkOutput("fault_cleared_pos", int'(plantIf.position), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);

    // Fault from DEAD outranks the dead-time countdown.
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("dead_fault", int'(plantIf.fault), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("dead_fault_cleared", int'(plantIf.fault), 0);

    // Climb to 7, turn down, then reset mid-move: homing is immediate.
    applyStimulus(1'b1, 1'b0, 1'b0, 9);
    checkOutput("pre_reset_up_pos", int'(plantIf.position), 7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    checkOutput("pre_reset_dn_pos",    int'(plantIf.position), 7);
    checkOutput("pre_reset_dn_moving", int'(plantIf.moving),   1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pos",      int'(plantIf.position), 0);
    checkOutput("async_rst_dn_limit", int'(plantIf.dn_limit), 1);
    checkOutput("async_rst_moving",   int'(plantIf.moving),   0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("post_rst_fault", int'(plantIf.fault), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
